// File: rtl/w5300_tx_packetizer.sv
// rtl/w5300_tx_packetizer.sv - frame assembly buffer feeding the W5300 UDP entry block
//
// Collects one frame of 16-bit words from a valid/ready stream into a local
// RAM (word 0 = payload word count, payload from word 1). It then raises
// tx_req and serves reads while the entry block copies the frame out.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   s_valid/s_data/s_last/s_ready   user payload stream
//   tx_req          level request: a complete frame is waiting
//   tx_buffer_addr  read address from the entry block
//   tx_data         read data, one cycle after tx_buffer_addr
//   busy_n          entry block idle when high
//   err_code        entry block status, sampled when busy_n returns high
//   frame_done      one-cycle pulse, frame sent cleanly
//   frame_err       one-cycle pulse, request timeout or nonzero err_code
//   overflow        one-cycle pulse after the s_last beat of a truncated frame
module w5300_tx_packetizer #(
    parameter int TX_BUFFER_ADDR_WIDTH = 12,
    parameter int REQ_TIMEOUT          = 100000,
    parameter int TIMEOUT_WIDTH        = 17
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            s_valid,
    input  logic [15:0]                     s_data,
    input  logic                            s_last,
    output logic                            s_ready,
    output logic                            tx_req,
    input  logic [TX_BUFFER_ADDR_WIDTH-1:0] tx_buffer_addr,
    output logic [15:0]                     tx_data,
    input  logic                            busy_n,
    input  logic [2:0]                      err_code,
    output logic                            frame_done,
    output logic                            frame_err,
    output logic                            overflow
);

    localparam int W = TX_BUFFER_ADDR_WIDTH;
    localparam logic [W-1:0] PTR_MAX = {W{1'b1}};
    localparam logic [W-1:0] PTR_FIRST = {{(W-1){1'b0}}, 1'b1};
    localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_WIDTH'(REQ_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_FILL,
        S_WRLEN,
        S_REQ,
        S_BUSY
    } state_t;

    state_t                   state_q, state_d;
    logic [W-1:0]             wr_ptr_q, wr_ptr_d;
    logic [W-1:0]             count_q, count_d;
    logic [TIMEOUT_WIDTH-1:0] tmo_q, tmo_d;
    logic                     trunc_q, trunc_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;
    logic                     ovf_q, ovf_d;
    logic [15:0]              tx_data_q;

    logic                     mem_we;
    logic [W-1:0]             mem_waddr;
    logic [15:0]              mem_wdata;
    logic [15:0]              mem [0:(1<<W)-1];

    logic                     beat;

    // Held low while rst is asserted so no beat is taken during reset.
    assign s_ready    = (state_q == S_FILL) && !rst;
    assign beat       = s_valid && s_ready;
    assign tx_req     = (state_q == S_REQ);
    assign tx_data    = tx_data_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign overflow   = ovf_q;

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        tmo_d     = '0;
        trunc_d   = trunc_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        ovf_d     = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = wr_ptr_q;
        mem_wdata = s_data;

        case (state_q)
            S_FILL: begin
                if (beat) begin
                    // Once the last slot is used, the rest of the frame is
                    // accepted but discarded.
                    if (!trunc_q) begin
                        mem_we = 1'b1;
                        if (wr_ptr_q != PTR_MAX) begin
                            wr_ptr_d = wr_ptr_q + 1'b1;
                            count_d  = count_q + 1'b1;
                        end else begin
                            trunc_d = 1'b1;
                            count_d = PTR_MAX;
                        end
                    end
                    if (s_last) begin
                        state_d = S_WRLEN;
                        ovf_d   = trunc_d;
                    end
                end
            end

            S_WRLEN: begin
                mem_we    = 1'b1;
                mem_waddr = '0;
                mem_wdata = 16'(count_q);
                trunc_d   = 1'b0;
                state_d   = S_REQ;
            end

            S_REQ: begin
                if (!busy_n) begin
                    state_d = S_BUSY;
                end else if (tmo_q == TIMEOUT_LAST) begin
                    err_d    = 1'b1;
                    wr_ptr_d = PTR_FIRST;
                    count_d  = '0;
                    state_d  = S_FILL;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            S_BUSY: begin
                if (busy_n) begin
                    done_d   = (err_code == 3'd0);
                    err_d    = (err_code != 3'd0);
                    wr_ptr_d = PTR_FIRST;
                    count_d  = '0;
                    state_d  = S_FILL;
                end
            end

            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FILL;
            wr_ptr_q  <= PTR_FIRST;
            count_q   <= '0;
            tmo_q     <= '0;
            trunc_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
            tx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            tmo_q     <= tmo_d;
            trunc_q   <= trunc_d;
            done_q    <= done_d;
            err_q     <= err_d;
            ovf_q     <= ovf_d;
            tx_data_q <= mem[tx_buffer_addr];
        end
    end

    // Buffer contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_w5300_tx_packetizer.sv
// tb/tb_w5300_tx_packetizer.sv - self-checking bench for w5300_tx_packetizer
module tb_w5300_tx_packetizer;

    localparam int W    = 4;
    localparam int MAXW = 15;
    localparam int TO   = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic [15:0]   s_data;
    logic          s_last;
    logic          s_ready;
    logic          tx_req;
    logic [W-1:0]  tx_buffer_addr;
    logic [15:0]   tx_data;
    logic          busy_n;
    logic [2:0]    err_code;
    logic          frame_done;
    logic          frame_err;
    logic          overflow;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] ref_mem [0:MAXW];
    logic [15:0] words [$];
    bit          mem0_valid = 1'b0;

    always #5 clk = ~clk;

    w5300_tx_packetizer #(
        .TX_BUFFER_ADDR_WIDTH(W),
        .REQ_TIMEOUT(TO),
        .TIMEOUT_WIDTH(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_valid(s_valid),
        .s_data(s_data),
        .s_last(s_last),
        .s_ready(s_ready),
        .tx_req(tx_req),
        .tx_buffer_addr(tx_buffer_addr),
        .tx_data(tx_data),
        .busy_n(busy_n),
        .err_code(err_code),
        .frame_done(frame_done),
        .frame_err(frame_err),
        .overflow(overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic make_words(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back(16'($urandom));
    endtask

    // mode: 0 normal, 1 request timeout, 2 reset during BUSY, 3 busy_n already low
    task automatic run_frame(input int n, input int delay, input logic [2:0] ec, input int mode);
        int stored;
        int cnt;
        bit ovf_exp;
        stored  = (n < MAXW) ? n : MAXW;
        ovf_exp = (n >= MAXW);
        busy_n  = 1'b1;

        if (mem0_valid) begin
            tx_buffer_addr = '0;
            @(negedge clk);
            chk("stale_len_read", tx_data, ref_mem[0]);
        end

        for (int i = 0; i < n; i++) begin
            while ($urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                @(negedge clk);
            end
            chk("s_ready_fill", s_ready, 1'b1);
            s_valid = 1'b1;
            s_data  = words[i];
            s_last  = (i == n - 1);
            @(negedge clk);
            if (i != n - 1) chk("overflow_mid", overflow, 1'b0);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;

        // Model: first min(n,15) words land at 1.., word 0 holds that count.
        for (int i = 0; i < stored; i++) ref_mem[i + 1] = words[i];
        ref_mem[0] = 16'(stored);

        chk("overflow_pulse", overflow, ovf_exp);
        chk("s_ready_wrlen", s_ready, 1'b0);
        chk("tx_req_wrlen", tx_req, 1'b0);
        if (mode == 3) busy_n = 1'b0;
        @(negedge clk);
        chk("tx_req_rise", tx_req, 1'b1);
        chk("s_ready_req", s_ready, 1'b0);
        chk("overflow_once", overflow, 1'b0);

        if (mode == 1) begin
            cnt = 0;
            while (tx_req && cnt < 40) begin
                cnt++;
                @(negedge clk);
            end
            chk("timeout_req_cycles", cnt, TO);
            chk("timeout_err", frame_err, 1'b1);
            chk("timeout_no_done", frame_done, 1'b0);
            chk("timeout_s_ready", s_ready, 1'b1);
            @(negedge clk);
            chk("timeout_err_once", frame_err, 1'b0);
            mem0_valid = 1'b1;
            return;
        end

        if (mode != 3) begin
            for (int d = 0; d < delay; d++) begin
                @(negedge clk);
                chk("tx_req_hold", tx_req, 1'b1);
                chk("s_ready_wait", s_ready, 1'b0);
            end
            busy_n = 1'b0;
        end
        @(negedge clk);
        chk("tx_req_drop", tx_req, 1'b0);

        for (int k = 0; k <= stored + 4; k++) begin
            int a;
            a = (k <= stored) ? k : int'($urandom_range(0, stored));
            tx_buffer_addr = W'(a);
            @(negedge clk);
            chk($sformatf("read_addr%0d", a), tx_data, ref_mem[a]);
            chk("s_ready_busy", s_ready, 1'b0);
        end

        if (mode == 2) begin
            rst = 1'b1;
            @(negedge clk);
            chk("rst_tx_req", tx_req, 1'b0);
            chk("rst_s_ready", s_ready, 1'b0);
            chk("rst_tx_data", tx_data, 16'h0);
            rst = 1'b0;
            @(negedge clk);
            chk("post_rst_s_ready", s_ready, 1'b1);
            chk("post_rst_tx_req", tx_req, 1'b0);
            busy_n = 1'b1;
            for (int d = 0; d < 3; d++) begin
                @(negedge clk);
                chk("post_rst_no_done", frame_done, 1'b0);
                chk("post_rst_no_err", frame_err, 1'b0);
            end
            mem0_valid = 1'b1;
            return;
        end

        busy_n   = 1'b1;
        err_code = ec;
        @(negedge clk);
        chk("frame_done", frame_done, (ec == 3'd0));
        chk("frame_err", frame_err, (ec != 3'd0));
        chk("s_ready_back", s_ready, 1'b1);
        chk("tx_req_idle", tx_req, 1'b0);
        err_code = 3'd0;
        @(negedge clk);
        chk("done_once", frame_done, 1'b0);
        chk("err_once", frame_err, 1'b0);
        mem0_valid = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit expired");
        $fatal(1);
    end

    initial begin
        int n;
        int sel;
        logic [2:0] ec;
        rst            = 1'b1;
        s_valid        = 1'b0;
        s_data         = '0;
        s_last         = 1'b0;
        tx_buffer_addr = '0;
        busy_n         = 1'b1;
        err_code       = 3'd0;
        repeat (2) @(negedge clk);
        chk("reset_s_ready", s_ready, 1'b0);
        chk("reset_tx_req", tx_req, 1'b0);
        chk("reset_tx_data", tx_data, 16'h0);
        chk("reset_frame_done", frame_done, 1'b0);
        chk("reset_frame_err", frame_err, 1'b0);
        chk("reset_overflow", overflow, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("after_reset_s_ready", s_ready, 1'b1);
        chk("after_reset_tx_req", tx_req, 1'b0);

        words = '{16'h1111, 16'h2222, 16'h3333};
        run_frame(3, 4, 3'd0, 0);
        words = '{16'hABCD};
        run_frame(1, 3, 3'd0, 0);
        make_words(20); run_frame(20, 2, 3'd0, 0);
        make_words(15); run_frame(15, 1, 3'd0, 0);
        make_words(14); run_frame(14, 0, 3'd0, 0);
        make_words(5);  run_frame(5, 0, 3'd0, 1);
        make_words(4);  run_frame(4, 2, 3'b010, 0);
        make_words(2);  run_frame(2, 1, 3'd0, 0);
        make_words(6);  run_frame(6, 0, 3'd0, 3);
        make_words(7);  run_frame(7, 1, 3'd0, 2);
        make_words(3);  run_frame(3, 0, 3'd0, 0);

        for (int f = 0; f < 25; f++) begin
            n   = $urandom_range(1, 20);
            sel = $urandom_range(0, 9);
            ec  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            make_words(n);
            run_frame(n, $urandom_range(0, 10), ec,
                      (sel == 7) ? 1 : (sel == 8) ? 3 : (sel == 9) ? 2 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
